// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer: valid/ready commands in, registered responses out.
// Optionally sweeps the whole file with INIT_VALUE after reset.
module regfile_access_ctrl #(
    parameter int                ADDR_W         = 5,
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              init_done_q;
    logic              rf_mode_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [ADDR_W-1:0] rf_raddr_q;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            init_done_q <= !CLEAR_ON_RESET;
            rf_mode_q   <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_raddr_q  <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    // Last sweep write is on the bus when the address is all-ones.
                    if (rf_mode_q && (rf_waddr_q == '1)) begin
                        rf_mode_q   <= 1'b0;
                        init_done_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        rf_mode_q  <= 1'b1;
                        rf_waddr_q <= cnt_q;
                        rf_wdata_q <= INIT_VALUE;
                        cnt_q      <= cnt_d;
                    end
                end
                S_IDLE: begin
                    rf_mode_q <= 1'b0;
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_write) begin
                            rf_mode_q  <= 1'b1;
                            rf_waddr_q <= cmd_addr;
                            rf_wdata_q <= cmd_data;
                            state_q    <= S_WRITE;
                        end else begin
                            rf_raddr_q <= cmd_addr;
                            state_q    <= S_READ;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    rf_mode_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_write_q <= 1'b1;
                    rsp_data_q  <= rf_wdata_q;
                    state_q     <= S_RESP;
                end
                S_READ: begin
                    rsp_valid_q <= 1'b1;
                    rsp_write_q <= 1'b0;
                    rsp_data_q  <= rf_rdata;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rf_mode_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_data  = rsp_data_q;
    assign init_done = init_done_q;
    assign rf_mode   = rf_mode_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_raddr  = rf_raddr_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a combinational register-file model.
// Instance a sweeps after reset; instance b starts straight in IDLE.
module tb_regfile_access_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_ready;

    logic          a_cmd_ready, a_rsp_valid, a_rsp_write, a_init_done, a_rf_mode;
    logic [DW-1:0] a_rsp_data, a_rf_wdata, a_rf_rdata;
    logic [AW-1:0] a_rf_waddr, a_rf_raddr;

    logic          b_cmd_ready, b_rsp_valid, b_rsp_write, b_init_done, b_rf_mode;
    logic [DW-1:0] b_rsp_data, b_rf_wdata;
    logic [AW-1:0] b_rf_waddr, b_rf_raddr;
    logic          b_cmd_valid = 1'b0;
    logic [DW-1:0] b_rf_rdata = '0;

    logic [DW-1:0] mem [32];
    int tests = 0;
    int fails = 0;
    int mode_cnt = 0;
    int b_mode_cnt = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .INIT_VALUE(32'h0), .CLEAR_ON_RESET(1'b1)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(a_rsp_write),
        .rsp_data(a_rsp_data), .init_done(a_init_done),
        .rf_mode(a_rf_mode), .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata),
        .rf_raddr(a_rf_raddr), .rf_rdata(a_rf_rdata)
    );

    regfile_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .INIT_VALUE(32'h0), .CLEAR_ON_RESET(1'b0)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(b_rsp_write),
        .rsp_data(b_rsp_data), .init_done(b_init_done),
        .rf_mode(b_rf_mode), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
        .rf_raddr(b_rf_raddr), .rf_rdata(b_rf_rdata)
    );

    always @(posedge clk) if (a_rf_mode) mem[a_rf_waddr] <= a_rf_wdata;
    assign a_rf_rdata = mem[a_rf_raddr];

    always @(negedge clk) if (a_rf_mode) mode_cnt <= mode_cnt + 1;
    always @(negedge clk) if (b_rf_mode) b_mode_cnt <= b_mode_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        n = 0;
        while (a_cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("issue_wait", 32'(n < 50), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d, output logic w, output int lat);
        lat = 0;
        while (a_rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("rsp_wait", 32'(lat < 20), 32'd1);
        d = a_rsp_data;
        w = a_rsp_write;
        tick();
        lat++;
    endtask

    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] din,
                          output logic [DW-1:0] d, output logic wr, output int lat);
        issue(w, a, din);
        wait_rsp(d, wr, lat);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          w;
        int            lat;
        int            m0;
        int            seq;
        int            bad;
        bit            seen_done;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(a_cmd_ready), 32'd0);
        chk("rst_rf_mode", 32'(a_rf_mode), 32'd0);
        chk("rst_init_done", 32'(a_init_done), 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_data", a_rsp_data, 32'h0);
        chk("rst_b_init_done", 32'(b_init_done), 32'd1);
        chk("rst_b_cmd_ready", 32'(b_cmd_ready), 32'd0);

        // Sweep: 32 mode cycles with ascending addresses, then ready + done together.
        rst_n     = 1'b1;
        m0        = mode_cnt;
        seq       = 0;
        bad       = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) chk("b_ready_first_edge", 32'(b_cmd_ready), 32'd1);
            if (a_rf_mode === 1'b1) begin
                if (a_rf_waddr !== seq[AW-1:0] || a_cmd_ready !== 1'b0) bad++;
                seq++;
            end
            if (a_init_done === 1'b1 && !seen_done) begin
                seen_done = 1'b1;
                chk("done_with_ready", 32'(a_cmd_ready), 32'd1);
                chk("done_mode_low", 32'(a_rf_mode), 32'd0);
            end
        end
        chk("sweep_addr_seq", bad, 0);
        chk("sweep_len", seq, 32);
        chk("sweep_mode_cycles", mode_cnt - m0, 32);
        chk("sweep_done", 32'(a_init_done), 32'd1);
        chk("b_no_mode", b_mode_cnt, 0);

        do_cmd(1'b0, 5'd0, '0, d, w, lat);
        chk("rd0", d, 32'h0);
        do_cmd(1'b0, 5'd17, '0, d, w, lat);
        chk("rd17", d, 32'h0);
        do_cmd(1'b0, 5'd31, '0, d, w, lat);
        chk("rd31", d, 32'h0);

        m0 = mode_cnt;
        do_cmd(1'b1, 5'd5, 32'hDEADBEEF, d, w, lat);
        chk("wr5_rsp_write", 32'(w), 32'd1);
        chk("wr5_rsp_data", d, 32'hDEADBEEF);
        chk("wr5_mode_pulse", mode_cnt - m0, 1);
        m0 = mode_cnt;
        do_cmd(1'b0, 5'd5, '0, d, w, lat);
        chk("rd5_rsp_write", 32'(w), 32'd0);
        chk("rd5_rsp_data", d, 32'hDEADBEEF);
        chk("rd5_latency", lat, 2);
        chk("rd5_no_mode", mode_cnt - m0, 0);
        chk("rd5_ready_back", 32'(a_cmd_ready), 32'd1);
        chk("rd5_valid_clear", 32'(a_rsp_valid), 32'd0);

        for (int a = 0; a < 32; a++)
            do_cmd(1'b1, a[AW-1:0], 32'(a) * 32'h01010101, d, w, lat);
        for (int a = 31; a >= 0; a--) begin
            do_cmd(1'b0, a[AW-1:0], '0, d, w, lat);
            chk($sformatf("rb%0d", a), d, 32'(a) * 32'h01010101);
        end

        // Backpressure with a pending write held by the source.
        rsp_ready = 1'b0;
        issue(1'b0, 5'd3, '0);
        tick();
        chk("bp_valid", 32'(a_rsp_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd4;
        cmd_data  = 32'h00000055;
        m0  = mode_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h03030303 ||
                a_rsp_write !== 1'b0 || a_cmd_ready !== 1'b0) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_no_write", mode_cnt - m0, 0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_consumed", 32'(a_rsp_valid), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_wr_mode", 32'(a_rf_mode), 32'd1);
        chk("bp_wr_addr", 32'(a_rf_waddr), 32'd4);
        wait_rsp(d, w, lat);
        chk("bp_wr_rsp", d, 32'h00000055);
        do_cmd(1'b0, 5'd4, '0, d, w, lat);
        chk("bp_rd4", d, 32'h00000055);

        // Reset in the middle of a write.
        issue(1'b1, 5'd9, 32'h12345678);
        chk("wr9_mode", 32'(a_rf_mode), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mode", 32'(a_rf_mode), 32'd0);
        chk("async_waddr", 32'(a_rf_waddr), 32'd0);
        chk("async_wdata", a_rf_wdata, 32'h0);
        chk("async_done", 32'(a_init_done), 32'd0);
        chk("async_ready", 32'(a_cmd_ready), 32'd0);
        #12 rst_n = 1'b1;
        tick();
        chk("resweep_mode", 32'(a_rf_mode), 32'd1);
        chk("resweep_addr0", 32'(a_rf_waddr), 32'd0);
        lat = 0;
        while (a_init_done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("resweep_done", 32'(a_init_done), 32'd1);
        do_cmd(1'b0, 5'd9, '0, d, w, lat);
        chk("rd9_after_reset", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
